ball_collision_sched: RTL and testbench

Sequencer that shares one ball-collision resolver datapath among `NUM_BALLS` balls. On each frame tick it snapshots all ball positions and walks every unordered pair in a fixed order. For each pair it tests for contact, dispatches overlapping pairs to the resolver, and strobes the velocity write-back. It sits between the per-ball position/velocity registers and the collision resolver, and runs once per VGA frame.

---
 rtl/ball_pkg.sv | 23 ++
 rtl/ball_collision_sched_pair_overlap_chk.sv | 33 +++
 rtl/ball_collision_sched.sv | 185 ++++++++++++++++++
 tb/tb_ball_collision_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared types and constants for the ball collision scheduler and its
// pair-contact checker.
package ball_pkg;

  localparam int POS_W     = 10;
  localparam int BALL_SIZE = 30;

  typedef logic [2:0] ball_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_NEXT  = 3'd5
  } state_t;

  function automatic int pair_count(input int n);
    return (n * (n - 1)) / 2;
  endfunction

endpackage

// File: rtl/ball_collision_sched_pair_overlap_chk.sv
// pair_overlap_chk: combinational contact test between two balls.
// Contact when the squared centre distance is <= CONTACT_DIST^2 (full 21-bit sum).
module pair_overlap_chk
  import ball_pkg::*;
#(
  parameter int CONTACT_DIST = BALL_SIZE
) (
  input  logic [POS_W-1:0] xa,
  input  logic [POS_W-1:0] ya,
  input  logic [POS_W-1:0] xb,
  input  logic [POS_W-1:0] yb,
  output logic             contact
);

  localparam int D2_W = 2 * POS_W + 1;
  localparam logic [D2_W-1:0] LIMIT = D2_W'(CONTACT_DIST * CONTACT_DIST);

  logic [POS_W-1:0]   dx;
  logic [POS_W-1:0]   dy;
  logic [2*POS_W-1:0] dx2;
  logic [2*POS_W-1:0] dy2;
  logic [D2_W-1:0]    d2;

  always_comb begin
    dx      = (xa >= xb) ? (xa - xb) : (xb - xa);
    dy      = (ya >= yb) ? (ya - yb) : (yb - ya);
    dx2     = {{POS_W{1'b0}}, dx} * {{POS_W{1'b0}}, dx};
    dy2     = {{POS_W{1'b0}}, dy} * {{POS_W{1'b0}}, dy};
    d2      = {1'b0, dx2} + {1'b0, dy2};
    contact = (d2 <= LIMIT);
  end

endmodule

// File: rtl/ball_collision_sched.sv
// ball_collision_sched: once per frame, snapshots ball positions and walks every
// pair, dispatching contacts to the shared resolver. Macro BALL_COLLISION_HOLDOFF_EN
// adds a per-pair hold-off so still-overlapping pairs are not resolved twice in a row.
module ball_collision_sched #(
  parameter int NUM_BALLS = 4,
  parameter int BALL_SIZE = ball_pkg::BALL_SIZE,
  parameter int TIMEOUT   = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 frame_tick,
  input  logic [ball_pkg::POS_W*NUM_BALLS-1:0] x_pos,
  input  logic [ball_pkg::POS_W*NUM_BALLS-1:0] y_pos,
  output logic                                 res_start,
  output ball_pkg::ball_idx_t                  res_sel_a,
  output ball_pkg::ball_idx_t                  res_sel_b,
  input  logic                                 res_done,
  output logic                                 upd_we,
  output logic                                 busy,
  output logic                                 sweep_done,
  output logic                                 overrun,
  output logic                                 timeout_err,
  output ball_pkg::state_t                     state_dbg
);
  import ball_pkg::*;

  localparam int         IDX_W     = $clog2(NUM_BALLS);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  // Resolver handshake: res_start is a one-cycle request carrying res_sel_a/b, which
  // stay stable until the write-back; res_done is a one-cycle answer honoured only in
  // WAIT, and upd_we follows it by exactly one cycle with the same selects.
  state_t           state;
  logic [POS_W-1:0] snap_x [NUM_BALLS];
  logic [POS_W-1:0] snap_y [NUM_BALLS];
  logic [IDX_W-1:0] pi;
  logic [IDX_W-1:0] pj;
  logic [7:0]       wait_cnt;
  logic             contact;
  logic             held;
  logic             dispatch;
  logic             is_last;

  assign state_dbg = state;
  assign is_last   = (pi == IDX_W'(NUM_BALLS - 2)) && (pj == IDX_W'(NUM_BALLS - 1));
  assign dispatch  = contact && !held;

  pair_overlap_chk #(
    .CONTACT_DIST(BALL_SIZE)
  ) u_chk (
    .xa      (snap_x[pi]),
    .ya      (snap_y[pi]),
    .xb      (snap_x[pj]),
    .yb      (snap_y[pj]),
    .contact (contact)
  );

`ifdef BALL_COLLISION_HOLDOFF_EN
  localparam int NPAIRS = pair_count(NUM_BALLS);
  localparam int PAIR_W = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;

  logic [NPAIRS-1:0] holdoff;
  logic [PAIR_W-1:0] pair_idx;

  assign held = holdoff[pair_idx];

  // pair_idx tracks the linear position of (pi,pj) in the sweep order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdoff  <= '0;
      pair_idx <= '0;
    end else begin
      if (state == ST_IDLE && frame_tick) begin
        pair_idx <= '0;
      end else if (state == ST_NEXT) begin
        pair_idx <= is_last ? '0 : pair_idx + PAIR_W'(1);
      end
      if (state == ST_CHECK && !contact) begin
        holdoff[pair_idx] <= 1'b0;
      end
      if (state == ST_WRITE) begin
        holdoff[pair_idx] <= 1'b1;
      end
    end
  end
`else
  assign held = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pi          <= '0;
      pj          <= IDX_W'(1);
      wait_cnt    <= '0;
      res_start   <= 1'b0;
      res_sel_a   <= '0;
      res_sel_b   <= '0;
      upd_we      <= 1'b0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      for (int k = 0; k < NUM_BALLS; k++) begin
        snap_x[k] <= '0;
        snap_y[k] <= '0;
      end
    end else begin
      res_start  <= 1'b0;
      upd_we     <= 1'b0;
      sweep_done <= 1'b0;
      if (frame_tick && state != ST_IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            for (int k = 0; k < NUM_BALLS; k++) begin
              snap_x[k] <= x_pos[POS_W*k +: POS_W];
              snap_y[k] <= y_pos[POS_W*k +: POS_W];
            end
            pi    <= '0;
            pj    <= IDX_W'(1);
            busy  <= 1'b1;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (dispatch) begin
            res_start <= 1'b1;
            res_sel_a <= ball_idx_t'(pi);
            res_sel_b <= ball_idx_t'(pj);
            state     <= ST_START;
          end else begin
            sweep_done <= is_last;
            state      <= ST_NEXT;
          end
        end
        ST_START: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // A res_done on the final allowed cycle still counts as an answer.
          if (res_done) begin
            upd_we <= 1'b1;
            state  <= ST_WRITE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            res_sel_a   <= '0;
            res_sel_b   <= '0;
            sweep_done  <= is_last;
            state       <= ST_NEXT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_WRITE: begin
          res_sel_a  <= '0;
          res_sel_b  <= '0;
          sweep_done <= is_last;
          state      <= ST_NEXT;
        end
        ST_NEXT: begin
          if (is_last) begin
            pi    <= '0;
            pj    <= IDX_W'(1);
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            if (pj == IDX_W'(NUM_BALLS - 1)) begin
              pi <= pi + IDX_W'(1);
              pj <= pi + IDX_W'(2);
            end else begin
              pj <= pj + IDX_W'(1);
            end
            state <= ST_CHECK;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_collision_sched.sv
// Bench for ball_collision_sched: a 2-ball and a 4-ball instance, swept with directed
// and random positions and checked against a pair-walk reference model.
module tb_ball_collision_sched;
  import ball_pkg::*;

  localparam int TIMEOUT = 255;
  localparam int CDIST   = 30;
`ifdef BALL_COLLISION_HOLDOFF_EN
  localparam bit HOLDOFF = 1'b1;
`else
  localparam bit HOLDOFF = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic tick_v, rd_v, use2_v;
  int   bx [8];
  int   by [8];

  logic [19:0] x2, y2;
  logic [39:0] x4, y4;

  always_comb begin
    x2 = '0; y2 = '0; x4 = '0; y4 = '0;
    for (int k = 0; k < 2; k++) begin
      x2[10*k +: 10] = 10'(bx[k]);
      y2[10*k +: 10] = 10'(by[k]);
    end
    for (int k = 0; k < 4; k++) begin
      x4[10*k +: 10] = 10'(bx[k]);
      y4[10*k +: 10] = 10'(by[k]);
    end
  end

  logic      start2, upd2, busy2, sd2, ov2, te2;
  logic      start4, upd4, busy4, sd4, ov4, te4;
  ball_idx_t sela2, selb2, sela4, selb4;
  state_t    st2, st4;

  ball_collision_sched #(.NUM_BALLS(2), .BALL_SIZE(CDIST), .TIMEOUT(TIMEOUT)) u_dut2 (
    .clk(clk), .rst(rst), .frame_tick(tick_v & use2_v), .x_pos(x2), .y_pos(y2),
    .res_start(start2), .res_sel_a(sela2), .res_sel_b(selb2), .res_done(rd_v & use2_v),
    .upd_we(upd2), .busy(busy2), .sweep_done(sd2), .overrun(ov2),
    .timeout_err(te2), .state_dbg(st2)
  );

  ball_collision_sched #(.NUM_BALLS(4), .BALL_SIZE(CDIST), .TIMEOUT(TIMEOUT)) u_dut4 (
    .clk(clk), .rst(rst), .frame_tick(tick_v & ~use2_v), .x_pos(x4), .y_pos(y4),
    .res_start(start4), .res_sel_a(sela4), .res_sel_b(selb4), .res_done(rd_v & ~use2_v),
    .upd_we(upd4), .busy(busy4), .sweep_done(sd4), .overrun(ov4),
    .timeout_err(te4), .state_dbg(st4)
  );

  logic      o_start, o_upd, o_busy, o_sd, o_ov, o_te;
  ball_idx_t o_sela, o_selb;
  assign o_start = use2_v ? start2 : start4;
  assign o_upd   = use2_v ? upd2   : upd4;
  assign o_busy  = use2_v ? busy2  : busy4;
  assign o_sd    = use2_v ? sd2    : sd4;
  assign o_ov    = use2_v ? ov2    : ov4;
  assign o_te    = use2_v ? te2    : te4;
  assign o_sela  = use2_v ? sela2  : sela4;
  assign o_selb  = use2_v ? selb2  : selb4;

  // scoreboard
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [5:0] exp_q[$];
  int         exp_cyc_q[$];
  bit         ho_m [2][28];
  bit         te_m [2];
  bit         ov_m [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_ball(input int k, input int x, input int y);
    bx[k] = x;
    by[k] = y;
  endtask

  task automatic clear_model();
    for (int m = 0; m < 2; m++) begin
      te_m[m] = 1'b0;
      ov_m[m] = 1'b0;
      for (int p = 0; p < 28; p++) ho_m[m][p] = 1'b0;
    end
  endtask

  // Reference: walk pairs in order, deciding contact from squared distance.
  task automatic model_sweep(input bit use2, input int dly, output int len,
                             output int nst, output int nwr);
    int n, inst, p, dx, dy;
    bit contact;
    n = use2 ? 2 : 4;
    inst = use2 ? 0 : 1;
    p = 0; len = 0; nst = 0; nwr = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = i + 1; j < n; j++) begin
        dx = bx[i] - bx[j]; if (dx < 0) dx = -dx;
        dy = by[i] - by[j]; if (dy < 0) dy = -dy;
        contact = (dx * dx + dy * dy) <= CDIST * CDIST;
        if (contact && !(HOLDOFF && ho_m[inst][p])) begin
          exp_q.push_back({3'(i), 3'(j)});
          exp_cyc_q.push_back(len + 2);
          nst++;
          if (dly > 0) begin
            len += 4 + dly;
            nwr++;
            ho_m[inst][p] = 1'b1;
          end else begin
            len += 3 + TIMEOUT;
            te_m[inst] = 1'b1;
          end
        end else begin
          if (!contact) ho_m[inst][p] = 1'b0;
          len += 2;
        end
        p++;
      end
    end
  endtask

  // dly = resolver answer delay after res_start (0 = silent resolver).
  task automatic run_sweep(input bit use2, input int dly, input int ov_at, input bit scramble);
    int len, nst, nwr, sd_cyc, busy_cnt, cnt, done_cyc, n_start, n_wr, inst;
    logic [5:0] cur;
    inst = use2 ? 0 : 1;
    use2_v = use2;
    exp_q.delete();
    exp_cyc_q.delete();
    model_sweep(use2, dly, len, nst, nwr);
    if (ov_at > 0) ov_m[inst] = 1'b1;
    sd_cyc = -1; busy_cnt = 0; cnt = 0; done_cyc = -10; n_start = 0; n_wr = 0; cur = '0;
    @(negedge clk);
    check_eq("busy_before", o_busy, 0);
    tick_v = 1'b1;
    for (int cyc = 1; cyc <= len + 40; cyc++) begin
      @(negedge clk);
      tick_v = (cyc == ov_at);
      rd_v = 1'b0;
      if (scramble && cyc == 1) begin
        for (int k = 0; k < 4; k++) set_ball(k, $urandom_range(0, 1023), $urandom_range(0, 1023));
      end
      if (sd_cyc >= 0) begin
        check_eq("busy_after", o_busy, 0);
        break;
      end
      if (o_busy) busy_cnt++;
      if (o_sd && sd_cyc < 0) sd_cyc = cyc;
      if (o_upd) begin
        n_wr++;
        check_eq("upd_lat", cyc, done_cyc + 1);
        check_eq("upd_sel", {o_sela, o_selb}, cur);
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          rd_v = 1'b1;
          done_cyc = cyc;
        end
      end
      if (o_start) begin
        n_start++;
        cur = {o_sela, o_selb};
        if (exp_q.size() > 0) begin
          check_eq("start_sel", cur, exp_q.pop_front());
          check_eq("start_cyc", cyc, exp_cyc_q.pop_front());
        end
        if (dly > 0) cnt = dly;
      end
    end
    tick_v = 1'b0;
    rd_v = 1'b0;
    check_eq("sweep_len", sd_cyc, len);
    check_eq("busy_cycles", busy_cnt, len);
    check_eq("n_start", n_start, nst);
    check_eq("n_write", n_wr, nwr);
    check_eq("timeout_err", o_te, te_m[inst]);
    check_eq("overrun", o_ov, ov_m[inst]);
  endtask

  task automatic reset_in_wait();
    int ups;
    use2_v = 1'b1;
    set_ball(0, 100, 100);
    set_ball(1, 120, 100);
    @(negedge clk);
    tick_v = 1'b1;
    @(negedge clk);
    tick_v = 1'b0;
    for (int k = 0; k < 20 && !start2; k++) @(negedge clk);
    check_eq("rst_start_seen", start2, 1);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_in_wait", st2, ST_WAIT);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_outs", {start2, sela2, selb2, upd2, busy2, sd2, ov2, te2}, 0);
    check_eq("rst_state", st2, ST_IDLE);
    rd_v = 1'b1;
    rst = 1'b0;
    clear_model();
    ups = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rd_v = 1'b0;
      if (upd2 || busy2) ups++;
    end
    check_eq("rst_no_activity", ups, 0);
  endtask

  initial begin
    rst = 1'b1; tick_v = 1'b0; rd_v = 1'b0; use2_v = 1'b1;
    for (int k = 0; k < 8; k++) set_ball(k, 0, 0);
    clear_model();
    @(negedge clk);
    check_eq("reset_outs2", {start2, sela2, selb2, upd2, busy2, sd2, ov2, te2}, 0);
    check_eq("reset_outs4", {start4, sela4, selb4, upd4, busy4, sd4, ov4, te4}, 0);
    check_eq("reset_state2", st2, ST_IDLE);
    check_eq("reset_state4", st4, ST_IDLE);
    rst = 1'b0;

    // N=2 directed: apart, contact, boundaries, hold-off persistence
    set_ball(0, 100, 100); set_ball(1, 200, 100); run_sweep(1, 5, 0, 0);
    set_ball(1, 120, 100);                        run_sweep(1, 5, 0, 0);
    set_ball(1, 131, 100);                        run_sweep(1, 5, 0, 0);
    set_ball(1, 130, 100);                        run_sweep(1, 3, 0, 0);
    set_ball(1, 300, 300);                        run_sweep(1, 3, 0, 0);
    set_ball(1, 118, 124);                        run_sweep(1, 2, 0, 0);
    run_sweep(1, 2, 0, 0);
    set_ball(1, 300, 300);                        run_sweep(1, 2, 0, 0);
    set_ball(1, 118, 124);                        run_sweep(1, 4, 0, 0);
    set_ball(1, 300, 300);                        run_sweep(1, 1, 0, 0);
    set_ball(1, 120, 100);                        run_sweep(1, TIMEOUT, 0, 0);
    set_ball(1, 300, 300);                        run_sweep(1, 1, 0, 0);
    set_ball(1, 120, 100);                        run_sweep(1, 0, 10, 0);

    // N=4 directed: only balls 1 and 3 touch
    set_ball(0, 100, 100); set_ball(1, 300, 200);
    set_ball(2, 500, 100); set_ball(3, 310, 210);
    run_sweep(0, 5, 0, 0);

    // N=4 random, positions disturbed mid-sweep to exercise the snapshot
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 4; k++) set_ball(k, 100 + $urandom_range(0, 80), 100 + $urandom_range(0, 80));
      run_sweep(0, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6), 0, 1);
    end

    reset_in_wait();
    set_ball(0, 100, 100); set_ball(1, 110, 110);
    run_sweep(1, 2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
